// File: rtl/vec3_op_sequencer.sv
// Multi-cycle vec3 arithmetic unit: one shared fixed-point multiplier for DOT/CROSS/SCALE, single-cycle ADD/SUB/NEG.
// Optional VEC3_SEQ_SAT_EN: saturate products and sums instead of wrapping.
module vec3_op_sequencer #(
  parameter int WORD_WIDTH = 32,
  parameter int FRAC_BITS  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [2:0]                op,
  input  logic [3*WORD_WIDTH-1:0]   a,
  input  logic [3*WORD_WIDTH-1:0]   b,
  input  logic [WORD_WIDTH-1:0]     s,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [3*WORD_WIDTH-1:0]   result,
  output logic                      out_err,
  output logic                      busy
);

  localparam int W = WORD_WIDTH;
`ifdef VEC3_SEQ_SAT_EN
  localparam int XW = W + 2;
  localparam logic signed [XW-1:0]  SUM_MAX  = {3'b000, {(W-1){1'b1}}};
  localparam logic signed [XW-1:0]  SUM_MIN  = {3'b111, {(W-1){1'b0}}};
  localparam logic signed [2*W-1:0] PROD_MAX = {{(W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W-1:0] PROD_MIN = {{(W+1){1'b1}}, {(W-1){1'b0}}};
`else
  localparam int XW = W;
`endif

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SUB   = 3'd1;
  localparam logic [2:0] OP_NEG   = 3'd2;
  localparam logic [2:0] OP_DOT   = 3'd3;
  localparam logic [2:0] OP_CROSS = 3'd4;
  localparam logic [2:0] OP_SCALE = 3'd5;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t                  state_reg, state_next;
  logic [2:0]              op_reg, op_next;
  logic [3*W-1:0]          a_reg, a_next, b_reg, b_next;
  logic signed [W-1:0]     s_reg, s_next;
  logic [2:0]              step_reg, step_next;
  logic signed [XW-1:0]    acc_reg, acc_next;
  logic [3*W-1:0]          result_reg, result_next;
  logic                    err_reg, err_next;

  // Index 0 is x (MSBs), 2 is z
  logic signed [W-1:0] in_a_c [3];
  logic signed [W-1:0] in_b_c [3];
  logic signed [W-1:0] a_c [3];
  logic signed [W-1:0] b_c [3];

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_comp
      assign in_a_c[gi] = a[(3-gi)*W-1 -: W];
      assign in_b_c[gi] = b[(3-gi)*W-1 -: W];
      assign a_c[gi]    = a_reg[(3-gi)*W-1 -: W];
      assign b_c[gi]    = b_reg[(3-gi)*W-1 -: W];
    end
  endgenerate

  function automatic logic signed [XW-1:0] ext(input logic signed [W-1:0] v);
    return XW'(v);
  endfunction

  function automatic logic [W-1:0] fit(input logic signed [XW-1:0] v);
`ifdef VEC3_SEQ_SAT_EN
    if (v > SUM_MAX)      return SUM_MAX[W-1:0];
    else if (v < SUM_MIN) return SUM_MIN[W-1:0];
    else                  return v[W-1:0];
`else
    return v;
`endif
  endfunction

  logic signed [W-1:0]   mul_a, mul_b, prod;
  logic signed [2*W-1:0] prod_full, prod_shift;
  logic signed [XW-1:0]  prod_ext;

  assign prod_full  = mul_a * mul_b;
  assign prod_shift = prod_full >>> FRAC_BITS;
`ifdef VEC3_SEQ_SAT_EN
  always_comb begin
    if (prod_shift > PROD_MAX)      prod = PROD_MAX[W-1:0];
    else if (prod_shift < PROD_MIN) prod = PROD_MIN[W-1:0];
    else                            prod = prod_shift[W-1:0];
  end
`else
  assign prod = prod_shift[W-1:0];
`endif
  assign prod_ext = ext(prod);

  // Multiplier operand schedule per op and step
  always_comb begin
    mul_a = a_c[0];
    mul_b = b_c[0];
    case (op_reg)
      OP_DOT: begin
        case (step_reg)
          3'd1:    begin mul_a = a_c[1]; mul_b = b_c[1]; end
          3'd2:    begin mul_a = a_c[2]; mul_b = b_c[2]; end
          default: begin mul_a = a_c[0]; mul_b = b_c[0]; end
        endcase
      end
      OP_SCALE: begin
        mul_b = s_reg;
        case (step_reg)
          3'd1:    mul_a = a_c[1];
          3'd2:    mul_a = a_c[2];
          default: mul_a = a_c[0];
        endcase
      end
      OP_CROSS: begin
        case (step_reg)
          3'd0:    begin mul_a = a_c[1]; mul_b = b_c[2]; end
          3'd1:    begin mul_a = a_c[2]; mul_b = b_c[1]; end
          3'd2:    begin mul_a = a_c[2]; mul_b = b_c[0]; end
          3'd3:    begin mul_a = a_c[0]; mul_b = b_c[2]; end
          3'd4:    begin mul_a = a_c[0]; mul_b = b_c[1]; end
          default: begin mul_a = a_c[1]; mul_b = b_c[0]; end
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    state_next  = state_reg;
    op_next     = op_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    s_next      = s_reg;
    step_next   = step_reg;
    acc_next    = acc_reg;
    result_next = result_reg;
    err_next    = err_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          op_next     = op;
          a_next      = a;
          b_next      = b;
          s_next      = s;
          step_next   = 3'd0;
          acc_next    = '0;
          err_next    = 1'b0;
          result_next = '0;
          state_next  = DONE;
          case (op)
            OP_ADD: result_next = {fit(ext(in_a_c[0]) + ext(in_b_c[0])),
                                   fit(ext(in_a_c[1]) + ext(in_b_c[1])),
                                   fit(ext(in_a_c[2]) + ext(in_b_c[2]))};
            OP_SUB: result_next = {fit(ext(in_a_c[0]) - ext(in_b_c[0])),
                                   fit(ext(in_a_c[1]) - ext(in_b_c[1])),
                                   fit(ext(in_a_c[2]) - ext(in_b_c[2]))};
            OP_NEG: result_next = {fit(-ext(in_a_c[0])),
                                   fit(-ext(in_a_c[1])),
                                   fit(-ext(in_a_c[2]))};
            OP_DOT, OP_CROSS, OP_SCALE: state_next = MUL;
            default: err_next = 1'b1;
          endcase
        end
      end
      MUL: begin
        step_next = step_reg + 3'd1;
        case (op_reg)
          OP_DOT: begin
            if (step_reg == 3'd0)      acc_next = prod_ext;
            else if (step_reg == 3'd1) acc_next = acc_reg + prod_ext;
            else begin
              result_next = {fit(acc_reg + prod_ext), {(2*W){1'b0}}};
              state_next  = DONE;
            end
          end
          OP_SCALE: begin
            if (step_reg == 3'd0)      result_next[3*W-1 -: W] = prod;
            else if (step_reg == 3'd1) result_next[2*W-1 -: W] = prod;
            else begin
              result_next[W-1:0] = prod;
              state_next         = DONE;
            end
          end
          OP_CROSS: begin
            // Even steps hold the minuend; odd steps emit one component
            case (step_reg)
              3'd1:    result_next[3*W-1 -: W] = fit(acc_reg - prod_ext);
              3'd3:    result_next[2*W-1 -: W] = fit(acc_reg - prod_ext);
              3'd5: begin
                result_next[W-1:0] = fit(acc_reg - prod_ext);
                state_next         = DONE;
              end
              default: acc_next = prod_ext;
            endcase
          end
          default: state_next = IDLE;
        endcase
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      op_reg     <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      s_reg      <= '0;
      step_reg   <= '0;
      acc_reg    <= '0;
      result_reg <= '0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      op_reg     <= op_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      s_reg      <= s_next;
      step_reg   <= step_next;
      acc_reg    <= acc_next;
      result_reg <= result_next;
      err_reg    <= err_next;
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign out_valid = (state_reg == DONE);
  assign result    = result_reg;
  assign out_err   = err_reg;

endmodule

// File: tb/tb_vec3_op_sequencer.sv
// Scoreboard bench for vec3_op_sequencer: driver queues expected results, monitor pops and compares.
module tb_vec3_op_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  op = '0;
  logic [95:0] a = '0;
  logic [95:0] b = '0;
  logic [31:0] s = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [95:0] result;
  logic        out_err;
  logic        busy;

  vec3_op_sequencer #(.WORD_WIDTH(32), .FRAC_BITS(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .s(s), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .out_err(out_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [95:0] res;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;
  int last_hs_cyc = -10;
  int hold_cnt = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Reference model: plain integer arithmetic on 64-bit values
  function automatic longint fitw(input longint v);
`ifdef VEC3_SEQ_SAT_EN
    if (v > 64'sd2147483647) return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
`else
    logic [31:0] t;
    t = v[31:0];
    return longint'($signed(t));
`endif
  endfunction

  function automatic longint pm(input longint x, input longint y);
    return fitw((x * y) >>> 16);
  endfunction

  function automatic longint comp(input logic [95:0] v, input int i);
    logic [31:0] t;
    t = v[95-32*i -: 32];
    return longint'($signed(t));
  endfunction

  function automatic logic [95:0] pack3(input longint x, input longint y, input longint z);
    logic [31:0] tx, ty, tz;
    tx = x[31:0]; ty = y[31:0]; tz = z[31:0];
    return {tx, ty, tz};
  endfunction

  function automatic exp_t model(input logic [2:0] o, input logic [95:0] av, input logic [95:0] bv,
                                 input logic [31:0] sv);
    exp_t e;
    longint ax, ay, az, bx, by, bz, sc;
    ax = comp(av, 0); ay = comp(av, 1); az = comp(av, 2);
    bx = comp(bv, 0); by = comp(bv, 1); bz = comp(bv, 2);
    sc = longint'($signed(sv));
    e.err = 1'b0;
    e.acc = 0;
    case (o)
      3'd0: begin e.res = pack3(fitw(ax + bx), fitw(ay + by), fitw(az + bz)); e.lat = 1; end
      3'd1: begin e.res = pack3(fitw(ax - bx), fitw(ay - by), fitw(az - bz)); e.lat = 1; end
      3'd2: begin e.res = pack3(fitw(-ax), fitw(-ay), fitw(-az)); e.lat = 1; end
      3'd3: begin e.res = pack3(fitw(pm(ax, bx) + pm(ay, by) + pm(az, bz)), 0, 0); e.lat = 4; end
      3'd4: begin
        e.res = pack3(fitw(pm(ay, bz) - pm(az, by)), fitw(pm(az, bx) - pm(ax, bz)),
                      fitw(pm(ax, by) - pm(ay, bx)));
        e.lat = 7;
      end
      3'd5: begin e.res = pack3(pm(ax, sc), pm(ay, sc), pm(az, sc)); e.lat = 4; end
      default: begin e.res = '0; e.err = 1'b1; e.lat = 1; end
    endcase
    return e;
  endfunction

  function automatic logic [31:0] rnd_comp();
    if ($urandom_range(0, 1) == 0) return $urandom;
    return $urandom_range(0, 32'h0010_0000) - 32'h0008_0000;
  endfunction

  task automatic issue(input logic [2:0] o, input logic [95:0] av, input logic [95:0] bv,
                       input logic [31:0] sv, input bit push, input exp_t e, output int acc_cyc);
    int n;
    exp_t ee;
    @(negedge clk);
    op = o; a = av; b = bv; s = sv; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready stayed %b, required 1", in_ready);
      in_valid = 1'b0;
      acc_cyc = -1;
      return;
    end
    acc_cyc = cyc + 1;
    if (push) begin
      ee = e;
      ee.acc = acc_cyc;
      q.push_back(ee);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic issue_model(input logic [2:0] o, input logic [95:0] av, input logic [95:0] bv,
                             input logic [31:0] sv, output int acc_cyc);
    issue(o, av, bv, sv, 1'b1, model(o, av, bv, sv), acc_cyc);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d results pending, required 0", q.size());
    end
  endtask

  task automatic monitor();
    bit   prev_valid = 1'b0;
    bit   have_cur = 1'b0;
    exp_t cur;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 1'b0;
        out_ready  = 1'b0;
        continue;
      end
      if (out_valid) begin
        chk("in_ready_while_done", 96'(in_ready), 96'(0));
        if (!prev_valid) begin
          if (q.size() == 0) begin
            checks++; errors++;
            have_cur = 1'b0;
            $display("FAIL unexpected_result: got %h err=%b, required no out_valid", result, out_err);
          end else begin
            cur = q.pop_front();
            have_cur = 1'b1;
            $display("txn acc_cycle=%0d latency=%0d result=%h err=%b", cur.acc, cyc - cur.acc + 1,
                     result, out_err);
            chk("result", result, cur.res);
            chk("out_err", 96'(out_err), 96'(cur.err));
            chk("latency", 96'(cyc - cur.acc + 1), 96'(cur.lat));
          end
        end else if (have_cur) begin
          chk("held_result", result, cur.res);
        end
        if (hold_cnt > 1) begin
          out_ready = 1'b0;
          hold_cnt--;
        end else if (hold_cnt == 1) begin
          out_ready = 1'b1;
          hold_cnt = 0;
        end else begin
          out_ready = ($urandom_range(0, 3) != 0);
        end
        if (out_ready) last_hs_cyc = cyc + 1;
      end else begin
        out_ready = $urandom_range(0, 1) != 0;
      end
      prev_valid = out_valid;
    end
  endtask

  initial begin
    exp_t e;
    int   ac, ac2;
    logic [2:0] ro;

    fork
      monitor();
    join_none

    // Reset state, with in_valid asserted to show it is ignored
    rst = 1'b1;
    in_valid = 1'b1;
    op = 3'd0;
    repeat (2) @(negedge clk);
    chk("reset_in_ready", 96'(in_ready), 96'(1));
    chk("reset_out_valid", 96'(out_valid), 96'(0));
    chk("reset_busy", 96'(busy), 96'(0));
    chk("reset_result", result, 96'(0));
    chk("reset_out_err", 96'(out_err), 96'(0));
    in_valid = 1'b0;
    rst = 1'b0;

    // DOT (1,2,3).(4,5,6) = 32.0
    e.err = 1'b0; e.acc = 0;
    e.res = {32'h0020_0000, 32'h0, 32'h0}; e.lat = 4;
    issue(3'd3, {32'h0001_0000, 32'h0002_0000, 32'h0003_0000},
          {32'h0004_0000, 32'h0005_0000, 32'h0006_0000}, 32'h0, 1'b1, e, ac);
    // CROSS x * y = z, and y * x = -z
    e.res = {32'h0, 32'h0, 32'h0001_0000}; e.lat = 7;
    issue(3'd4, {32'h0001_0000, 32'h0, 32'h0}, {32'h0, 32'h0001_0000, 32'h0}, 32'h0, 1'b1, e, ac);
    e.res = {32'h0, 32'h0, 32'hFFFF_0000};
    issue(3'd4, {32'h0, 32'h0001_0000, 32'h0}, {32'h0001_0000, 32'h0, 32'h0}, 32'h0, 1'b1, e, ac);
    // SCALE (1.5,-2,0.25) * 2
    e.res = {32'h0003_0000, 32'hFFFC_0000, 32'h0000_8000}; e.lat = 4;
    issue(3'd5, {32'h0001_8000, 32'hFFFE_0000, 32'h0000_4000}, 96'h0, 32'h0002_0000, 1'b1, e, ac);
    // SCALE overflow
`ifdef VEC3_SEQ_SAT_EN
    e.res = {32'h7FFF_FFFF, 32'h0, 32'h0};
`else
    e.res = {32'hFFFE_0000, 32'h0, 32'h0};
`endif
    issue(3'd5, {32'h7FFF_0000, 32'h0, 32'h0}, 96'h0, 32'h0002_0000, 1'b1, e, ac);
    // Illegal op
    e.res = '0; e.err = 1'b1; e.lat = 1;
    issue(3'd7, {3{32'h1234_5678}}, {3{32'h0BAD_F00D}}, 32'h0, 1'b1, e, ac);
    // NEG of the most negative value
    e.err = 1'b0;
`ifdef VEC3_SEQ_SAT_EN
    e.res = {32'h7FFF_FFFF, 32'hFFFF_0000, 32'h0};
`else
    e.res = {32'h8000_0000, 32'hFFFF_0000, 32'h0};
`endif
    issue(3'd2, {32'h8000_0000, 32'h0001_0000, 32'h0}, 96'h0, 32'h0, 1'b1, e, ac);
    drain();

    // Backpressure: five cycles of out_ready low, next op held waiting
    hold_cnt = 6;
    e.res = {3{32'h0003_0000}}; e.err = 1'b0; e.lat = 1;
    issue(3'd0, {3{32'h0001_0000}}, {3{32'h0002_0000}}, 32'h0, 1'b1, e, ac);
    issue_model(3'd1, {3{32'h0005_0000}}, {3{32'h0002_0000}}, 32'h0, ac2);
    chk("accept_after_handshake", 96'(ac2), 96'(last_hs_cyc + 1));
    chk("backpressure_span", 96'(last_hs_cyc - ac >= 6), 96'(1));
    drain();

    // Reset in the middle of a CROSS: the result must never appear
    issue(3'd4, {3{32'h0001_0000}}, {3{32'h0002_0000}}, 32'h0, 1'b0, e, ac);
    while (cyc < ac + 3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midreset_busy", 96'(busy), 96'(0));
    chk("midreset_out_valid", 96'(out_valid), 96'(0));
    chk("midreset_in_ready", 96'(in_ready), 96'(1));
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("midreset_no_result", 96'(out_valid), 96'(0));

    // Randomized traffic against the reference model
    for (int i = 0; i < 60; i++) begin
      ro = 3'($urandom_range(0, 7));
      issue_model(ro, {rnd_comp(), rnd_comp(), rnd_comp()}, {rnd_comp(), rnd_comp(), rnd_comp()},
                  rnd_comp(), ac);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vec3_op_sequencer.md
# vec3_op_sequencer

Multi-cycle vec3 arithmetic unit for the ray-marcher datapath. It time-multiplexes one shared signed fixed-point multiplier across the dot, cross and scale operations, and performs add, sub and neg in a single cycle. Upstream blocks (ray stepper, normal estimator) issue one operation at a time over a valid/ready handshake and receive a packed vec3 result over a second valid/ready handshake.

## Interface
Parameters:
- WORD_WIDTH, 32, component width (signed fixed point)
- FRAC_BITS, 16, fractional bits (Q16.16 by default)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operation request
- in_ready  out  1  high only in IDLE
- op  in  3  0 ADD, 1 SUB, 2 NEG, 3 DOT, 4 CROSS, 5 SCALE, 6/7 illegal
- a  in  3*WORD_WIDTH  packed {x,y,z}; x in the MSBs
- b  in  3*WORD_WIDTH  second vector; ignored for NEG and SCALE
- s  in  WORD_WIDTH  scalar for SCALE only
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts the result
- result  out  3*WORD_WIDTH  packed {x,y,z}; DOT returns the scalar in x with y=z=0
- out_err  out  1  illegal op flag; qualified by out_valid
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, MUL, DONE.
- IDLE
  - in_ready=1.
  - On in_valid, register op, a, b and s.
  - ADD, SUB, NEG and illegal ops go straight to DONE, with the result computed on the accept edge.
  - DOT, SCALE and CROSS go to MUL with step counter = 0.
- MUL
  - One product per cycle on the shared multiplier.
  - Step counts: DOT/SCALE 3 steps, CROSS 6 steps.
  - The last step's edge writes the final result and goes to DONE.
- DONE
  - out_valid=1; result and out_err are held stable.
  - On out_ready, go to IDLE.
- Product rule
  - Full 2*WORD_WIDTH signed product, arithmetic shift right by FRAC_BITS, keep the low WORD_WIDTH bits.
  - This is bit-exact with the team's fp_mul.
- Operation results
  - DOT: acc = p(ax,bx) + p(ay,by) + p(az,bz), with each product truncated before summing; the sum wraps at WORD_WIDTH.
  - SCALE: x=p(ax,s), y=p(ay,s), z=p(az,s), in that step order.
  - CROSS: step order p0=ay*bz, p1=az*by, p2=az*bx, p3=ax*bz, p4=ax*by, p5=ay*bx. Then x=p0-p1, y=p2-p3, z=p4-p5, with wrapping subtraction.
  - ADD/SUB: per-component wrapping add or subtract.
  - NEG: two's complement per component (~a+1), so the most negative value maps to itself.
  - Illegal op: result=0, out_err=1.
- No overlap: a new operation cannot be accepted until the previous result is consumed.

## Timing
- Reset values: state=IDLE, out_valid=0, out_err=0, busy=0, result=0, step counter=0. in_ready is 1 during and after reset.
- in_valid is ignored while rst is high.
- Acceptance occurs on the edge where in_valid && in_ready. Call that edge cycle 0.
- out_valid rises at:
  - cycle 1 for ADD/SUB/NEG/illegal
  - cycle 4 for DOT/SCALE
  - cycle 7 for CROSS
- DONE with out_ready=1 returns to IDLE on the next edge. in_ready is high the following cycle, giving 1 bubble cycle between results.
- out_ready held low keeps the block in DONE indefinitely, with result unchanged and in_ready=0.
- out_ready asserted before out_valid has no effect.
- Reset mid-operation (MUL or DONE): on the next edge, IDLE is entered and the partial result is discarded. No out_valid pulse is produced.
- Operands are sampled only at accept; input changes during MUL do not affect the result.

## Configuration
- VEC3_SEQ_SAT_EN: when defined, every shifted product and every final sum or difference is computed at least 2 bits wider and then saturated to [-2^(W-1), 2^(W-1)-1] instead of wrapping.
  - NEG of the most negative value saturates to the maximum value.
  - Latency is unchanged.
- Undefined (default): wrapping behaviour as described in Operation, bit-exact with the vector package.

## Test plan
- DOT, a=(1.0,2.0,3.0) (0x00010000, 0x00020000, 0x00030000), b=(4.0,5.0,6.0) -> result.x=0x00200000 (32.0), y=z=0, out_valid at cycle 4, out_err=0.
- CROSS, a=(1,0,0), b=(0,1,0) -> result=(0,0,0x00010000) at cycle 7; also check the swapped operands give z=0xFFFF0000.
- SCALE, a=(1.5,-2.0,0.25), s=2.0 -> result=(0x00030000, 0xFFFC0000, 0x00008000) at cycle 4.
- Backpressure: ADD (1,1,1)+(2,2,2) with out_ready low for 5 cycles -> result (3,3,3) stable and in_ready=0 throughout; a second in_valid is not accepted until 1 cycle after the out_ready handshake.
- Reset at MUL step 3 of CROSS -> next cycle: state IDLE, out_valid=0, in_ready=1; no result ever appears.
- SCALE, a.x=0x7FFF0000, s=2.0 -> result.x=0xFFFE0000 without VEC3_SEQ_SAT_EN, 0x7FFFFFFF with it. Separately, op=7 -> out_err=1, result=0 at cycle 1.
